// File: rtl/bcd_disp_pkg.sv
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared constants for the BCD 7-segment scan display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

    localparam int DIG_W = 2;
    typedef logic [DIG_W-1:0] dig_idx_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Non-decimal nibbles show 'E' so corrupt data is visible on the board
    always_comb begin
        o_seg = SEG_E;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_E;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scan.sv
// ============================================================================
// Module      : bcd_display_scan
// Description : Captures packed BCD + carry and scans it onto a 4-digit
//               common-anode 7-segment display with blanking and blink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_FRAMES  = 128,
    parameter bit BLANK_LEADING = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        ovf_in,
    input  logic        ovf_clr,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        bcd_err
);

    localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RCW-1:0] c_refresh_last = RCW'(REFRESH_DIV - 1);
    localparam logic [BCW-1:0] c_blink_last   = BCW'(BLINK_FRAMES - 1);
    localparam dig_idx_t       c_dig_last     = DIG_W'(3);

    logic [15:0]    r_shadow;
    logic           r_ovf_lat;
    logic [RCW-1:0] r_refresh_cnt;
    dig_idx_t       r_dig_idx;
    logic [BCW-1:0] r_blink_cnt;
    logic           r_blink_ph;

    logic           w_slot_end;
    logic           w_frame_end;
    logic [3:0]     w_nib_zero;
    logic [3:0]     w_nib_bad;
    logic [3:0]     w_lead_zero;
    logic [3:0]     w_digit;
    logic           w_blank;
    logic [6:0]     w_seg;
    logic [3:0]     w_an_on;

    assign w_slot_end  = (r_refresh_cnt == c_refresh_last);
    assign w_frame_end = w_slot_end && (r_dig_idx == c_dig_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_ovf_lat <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= value;
            end
            if (ovf_clr) begin
                r_ovf_lat <= 1'b0;
            end else if (load && ovf_in) begin
                r_ovf_lat <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_dig_idx     <= '0;
        end else if (w_slot_end) begin
            r_refresh_cnt <= '0;
            r_dig_idx     <= r_dig_idx + DIG_W'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RCW'(1);
        end
    end

    // Blink phase only advances on whole-frame boundaries so a dark half
    // never cuts a scan short
    always_ff @(posedge clk) begin
        if (rst || !r_ovf_lat) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_frame_end) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCW'(1);
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_nibble
        assign w_nib_zero[i] = (r_shadow[4*i +: 4] == 4'd0);
        assign w_nib_bad[i]  = (r_shadow[4*i +: 4] > 4'd9);
    end

    // w_lead_zero[i]: digit i and every more-significant digit are zero
    always_comb begin
        w_lead_zero    = '0;
        w_lead_zero[3] = w_nib_zero[3];
        for (int i = 2; i >= 0; i--) begin
            w_lead_zero[i] = w_nib_zero[i] & w_lead_zero[i+1];
        end
    end

    assign w_digit = r_shadow[4*r_dig_idx +: 4];
    assign w_blank = BLANK_LEADING && (r_dig_idx != '0) && w_lead_zero[r_dig_idx];
    assign w_an_on = ANODE_OFF ^ (4'b0001 << r_dig_idx);

    bcd_to_seg u_bcd_to_seg (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an      <= ANODE_OFF;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
            bcd_err <= 1'b0;
        end else begin
            an      <= (r_ovf_lat && r_blink_ph) ? ANODE_OFF : w_an_on;
            seg     <= w_seg;
            dp      <= ~(r_ovf_lat && (r_dig_idx == c_dig_last));
            bcd_err <= |w_nib_bad;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
// ============================================================================
// Module      : tb_bcd_display_scan
// Description : Scoreboard bench for bcd_display_scan, with and without
//               leading-zero blanking, against a behavioural display model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scan;

    localparam int RD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        ovf_in = 1'b0;
    logic        ovf_clr = 1'b0;

    logic [3:0]  an_b,  an_nb;
    logic [6:0]  seg_b, seg_nb;
    logic        dp_b,  dp_nb;
    logic        err_b, err_nb;

    always #5 clk = ~clk;

    bcd_display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .BLANK_LEADING(1'b1)) dut_b (
        .clk(clk), .rst(rst), .value(value), .load(load), .ovf_in(ovf_in),
        .ovf_clr(ovf_clr), .an(an_b), .seg(seg_b), .dp(dp_b), .bcd_err(err_b)
    );

    bcd_display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load), .ovf_in(ovf_in),
        .ovf_clr(ovf_clr), .an(an_nb), .seg(seg_nb), .dp(dp_nb), .bcd_err(err_nb)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg_b;
        logic [6:0] seg_nb;
        logic       dp;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model state: cycles since reset, shown value, sticky overflow, and
    // number of completed frames since the overflow was latched
    int          m_t      = 0;
    int          m_frames = 0;
    bit          m_lat    = 0;
    logic [15:0] m_shadow = '0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d, input bit blank_lead);
        logic [15:0] upper;
        int          nib;
        upper = v >> (4*d);
        nib   = int'(upper & 16'h000F);
        if (blank_lead && d > 0 && upper == 16'h0) return 7'b1111111;
        if (nib > 9) return 7'b0000110;
        return seg_tab[nib];
    endfunction

    task automatic model_step();
        exp_t e;
        int   dig;
        bit   ph;
        if (rst) begin
            e = '{an: 4'hF, seg_b: 7'h7F, seg_nb: 7'h7F, dp: 1'b1, err: 1'b0};
            m_t = 0; m_frames = 0; m_lat = 0; m_shadow = '0;
        end else begin
            dig      = (m_t / RD) % 4;
            ph       = ((m_frames / BF) % 2) == 1;
            e.an     = (m_lat && ph) ? 4'hF : (4'hF ^ (4'b0001 << dig));
            e.seg_b  = ref_seg(m_shadow, dig, 1'b1);
            e.seg_nb = ref_seg(m_shadow, dig, 1'b0);
            e.dp     = !(m_lat && dig == 3);
            e.err    = 1'b0;
            for (int i = 0; i < 4; i++)
                if (((m_shadow >> (4*i)) & 16'hF) > 16'd9) e.err = 1'b1;
            if (!m_lat) m_frames = 0;
            else if ((m_t % RD) == RD - 1 && dig == 3) m_frames++;
            m_t++;
            if (ovf_clr) m_lat = 0;
            else if (load && ovf_in) m_lat = 1;
            if (load) m_shadow = value;
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: the display presents a new output word on every clock
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty cyc=%0d", cyc);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (an_b !== e.an || seg_b !== e.seg_b || dp_b !== e.dp || err_b !== e.err) begin
                failures++;
                $display("FAIL blank_dut cyc=%0d got an=%b seg=%b dp=%b err=%b want an=%b seg=%b dp=%b err=%b",
                         cyc, an_b, seg_b, dp_b, err_b, e.an, e.seg_b, e.dp, e.err);
            end
            checks++;
            if (an_nb !== e.an || seg_nb !== e.seg_nb || dp_nb !== e.dp || err_nb !== e.err) begin
                failures++;
                $display("FAIL noblank_dut cyc=%0d got an=%b seg=%b dp=%b err=%b want an=%b seg=%b dp=%b err=%b",
                         cyc, an_nb, seg_nb, dp_nb, err_nb, e.an, e.seg_nb, e.dp, e.err);
            end
        end
    end

    task automatic drive(input logic [15:0] v, input logic ld, input logic oi,
                         input logic oc, input logic r);
        @(negedge clk);
        value = v; load = ld; ovf_in = oi; ovf_clr = oc; rst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(value, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] rv;
        drive(16'h0, 0, 0, 0, 1);
        drive(16'h0, 0, 0, 0, 1);
        idle(20);
        drive(16'h0205, 1, 0, 0, 0); idle(20);
        drive(16'h0010, 1, 0, 0, 0); idle(20);
        drive(16'h1A3F, 1, 0, 0, 0); idle(20);
        drive(16'h0550, 1, 0, 0, 0); idle(20);
        drive(16'h0000, 1, 1, 0, 0); idle(100);
        drive(16'h0000, 0, 0, 1, 0); idle(20);
        drive(16'h1234, 1, 0, 0, 0);
        for (int k = 0; k < 40 && !(((m_t / RD) % 4) == 2 && (m_t % RD) == 1); k++) idle(1);
        drive(16'h1234, 0, 0, 0, 1);
        idle(20);
        drive(16'h0777, 1, 1, 1, 0); idle(20);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 1) == 0)
                rv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                rv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
            drive(rv, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        end
        idle(3);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
